// File: rtl/permuter_swap_ctrl.sv
// Registered swap-decision controller for one 2x2 permuter stage.
// Picks a winner per cycle (golden > starved > older > round-robin) and registers swap/deflect one cycle later.
module permuter_swap_ctrl #(
   parameter int AGE_W        = 8,
   parameter int STARVE_W     = 4,
   parameter int STARVE_LIMIT = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                in_valid0,
   input  logic                in_valid1,
   input  logic                in_dir0,
   input  logic                in_dir1,
   input  logic [AGE_W-1:0]    in_age0,
   input  logic [AGE_W-1:0]    in_age1,
   input  logic                in_golden0,
   input  logic                in_golden1,
   output logic                swap,
   output logic                deflect0,
   output logic                deflect1,
   output logic                winner,
   output logic                rr_ptr,
   output logic [STARVE_W-1:0] starve_cnt0,
   output logic [STARVE_W-1:0] starve_cnt1
);

   localparam logic [STARVE_W-1:0] LIMIT   = STARVE_W'(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      RULE_IDLE,
      RULE_SINGLE,
      RULE_GOLDEN,
      RULE_STARVE,
      RULE_AGE,
      RULE_RR
   } rule_t;

   rule_t               rule;
   logic                starved0;
   logic                starved1;
   logic                conflict;
   logic                win_next;
   logic                swap_next;
   logic                deflect0_next;
   logic                deflect1_next;
   logic                rr_next;
   logic [STARVE_W-1:0] cnt0_next;
   logic [STARVE_W-1:0] cnt1_next;

   always_comb begin
      rule          = RULE_IDLE;
      win_next      = 1'b0;
      swap_next     = 1'b0;
      deflect0_next = 1'b0;
      deflect1_next = 1'b0;
      rr_next       = rr_ptr;
      cnt0_next     = starve_cnt0;
      cnt1_next     = starve_cnt1;

      starved0 = (starve_cnt0 >= LIMIT);
      starved1 = (starve_cnt1 >= LIMIT);
      conflict = in_valid0 && in_valid1 && (in_dir0 == in_dir1);

      if (in_valid0 && !in_valid1) begin
         rule     = RULE_SINGLE;
         win_next = 1'b0;
      end else if (!in_valid0 && in_valid1) begin
         rule     = RULE_SINGLE;
         win_next = 1'b1;
      end else if (in_valid0 && in_valid1) begin
         if (in_golden0 != in_golden1) begin
            rule     = RULE_GOLDEN;
            win_next = in_golden1;
         end else if (starved0 != starved1) begin
            rule     = RULE_STARVE;
            win_next = starved1;
         end else if (in_age0 != in_age1) begin
            rule     = RULE_AGE;
            win_next = (in_age1 > in_age0);
         end else begin
            rule     = RULE_RR;
            win_next = rr_ptr;
         end
      end

      if (rule != RULE_IDLE) begin
         swap_next = win_next ? ~in_dir1 : in_dir0;
      end

      deflect0_next = conflict && win_next;
      deflect1_next = conflict && !win_next;

      // The pointer only advances when it actually settled a contested output.
      if (rule == RULE_RR && conflict) begin
         rr_next = ~rr_ptr;
      end

      if (in_valid0) begin
         if (deflect0_next) begin
            cnt0_next = (starve_cnt0 == CNT_MAX) ? CNT_MAX : starve_cnt0 + 1'b1;
         end else begin
            cnt0_next = '0;
         end
      end
      if (in_valid1) begin
         if (deflect1_next) begin
            cnt1_next = (starve_cnt1 == CNT_MAX) ? CNT_MAX : starve_cnt1 + 1'b1;
         end else begin
            cnt1_next = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         swap        <= 1'b0;
         deflect0    <= 1'b0;
         deflect1    <= 1'b0;
         winner      <= 1'b0;
         rr_ptr      <= 1'b0;
         starve_cnt0 <= '0;
         starve_cnt1 <= '0;
      end else if (!stall) begin
         swap        <= swap_next;
         deflect0    <= deflect0_next;
         deflect1    <= deflect1_next;
         winner      <= win_next;
         rr_ptr      <= rr_next;
         starve_cnt0 <= cnt0_next;
         starve_cnt1 <= cnt1_next;
      end
   end

endmodule

// File: doc/permuter_swap_ctrl.md
Name: permuter_swap_ctrl

Overview:
- Registered swap-decision controller for one 2x2 permuter stage in the bufferless router pipeline.
- Arbitrates the two flits entering the stage by golden flag, starvation state, age and a round-robin tie-break.
- Drives the stage's swap select and reports per-lane deflection one cycle after the flit headers are presented.
- The parent pipelines the flit payloads alongside it so that the decision and the flits arrive at the permuter together.

Parameters:
AGE_W, 8, width of flit age/priority field (larger = older)
STARVE_W, 4, width of per-lane starvation counter
STARVE_LIMIT, 12, deflection count at which a lane gains override priority (must be < 2^STARVE_W)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = hold all registered outputs and internal state
in_valid0  input  1  lane-0 flit valid
in_valid1  input  1  lane-1 flit valid
in_dir0  input  1  lane-0 desired output (0 = outFlit0, 1 = outFlit1)
in_dir1  input  1  lane-1 desired output
in_age0  input  AGE_W  lane-0 age
in_age1  input  AGE_W  lane-1 age
in_golden0  input  1  lane-0 golden flag
in_golden1  input  1  lane-1 golden flag
swap  output  1  registered permuter select (1 = cross)
deflect0  output  1  registered: lane-0 flit sent to its non-desired output
deflect1  output  1  registered: lane-1 flit sent to its non-desired output
winner  output  1  registered index of the winning lane
rr_ptr  output  1  current round-robin tie-break pointer (favoured lane)
starve_cnt0  output  STARVE_W  lane-0 starvation counter
starve_cnt1  output  STARVE_W  lane-1 starvation counter

Behaviour:
- Reset: swap, deflect0/1, winner, rr_ptr and both starve counters are set to 0. Reset has priority over stall. A reset asserted mid-stream discards the in-flight decision.
- Latency: exactly 1 cycle from inputs to swap/deflect/winner when stall = 0.
- Stall = 1: no state changes and outputs hold. Inputs are ignored for that cycle.
- Winner selection (combinational, then registered):
  1. Neither lane valid: winner = 0, swap = 0, deflect0 = deflect1 = 0.
  2. Exactly one lane valid: that lane wins.
  3. Both lanes valid, evaluated in this order:
     a. The golden flags differ: the golden lane wins.
     b. Exactly one starve counter is >= STARVE_LIMIT: that lane wins.
     c. in_age differ: the larger age wins (unsigned compare).
     d. Otherwise: the lane rr_ptr wins. rr_ptr toggles on the same edge.
- Both golden, or both starved, fall through to the next rule.
- rr_ptr changes only when rule 3d is used.
- Swap: swap = in_dir[winner] XOR winner, so the winner always reaches its desired output.
- Deflection:
  - Both valid and in_dir0 == in_dir1: the loser is deflected (deflect[loser] = 1).
  - Otherwise, no lane is deflected.
  - An invalid lane always reports deflect = 0.
- Starvation counter, per lane, updated when not stalled:
  - Valid and deflected: increment, saturating at 2^STARVE_W-1.
  - Valid and not deflected: clear to 0.
  - Invalid: hold.
- Counter updates use the decision being registered that cycle, so the counters and deflect outputs move on the same edge.

Test Plan:
- Reset, then idle: both lanes invalid -> swap = 0, deflect = 00, winner = 0, rr_ptr = 0, counters = 0.
- Single flit: valid0 = 1, dir0 = 1, valid1 = 0 -> next cycle swap = 1, winner = 0, deflect = 00.
- Conflict by age: both valid, dir = 0/0, age0 = 5, age1 = 9 -> swap = 1, winner = 1, deflect0 = 1, starve_cnt0 = 1.
- Golden override: age0 = 200 non-golden, age1 = 3 golden, both dir = 1 -> winner = 1, swap = 0, deflect0 = 1.
- Tie-break: both valid, equal ages, same dir, for 4 consecutive cycles -> winner alternates 0, 1, 0, 1 and rr_ptr toggles each cycle.
  - In a separate run with no conflict that cycle (dir differ), rr_ptr is unchanged.
- Starvation and stall:
  - Lane 0 repeatedly loses on age for 12 cycles -> starve_cnt0 reaches 12, and lane 0 then wins despite the lower age. starve_cnt0 clears to 0 on that win.
  - Assert stall mid-sequence: all outputs and counters are frozen for the stalled cycles.
  - Assert reset while stalled: all values return to 0 on the next edge.
